dcache_ctrl: RTL



---
 rtl/dcache_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a line-wide main memory. Misses stall the pipeline, write back a dirty
// victim, then fill the line through a request/ready handshake.
module dcache_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cpu_re,
  input  logic                                    cpu_we,
  input  logic [ADDR_W-1:0]                       cpu_addr,
  input  logic [DATA_W-1:0]                       cpu_wdata,
  output logic [DATA_W-1:0]                       cpu_rdata,
  output logic                                    cpu_stall,
  output logic                                    mem_rd_req,
  output logic                                    mem_wr_req,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]    mem_addr,
  output logic [DATA_W*LINE_WORDS-1:0]            mem_wdata,
  input  logic [DATA_W*LINE_WORDS-1:0]            mem_rdata,
  input  logic                                    mem_ready,
  output logic [15:0]                             miss_cnt
);

  localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned LADDR_W = ADDR_W - OFF_W;
  localparam int unsigned LINE_W  = DATA_W * LINE_WORDS;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRBACK,
    FILL
  } state_t;

  state_t state_q, state_d;

  // Line storage: data and tags are not reset, valid/dirty are.
  logic [DATA_W-1:0] data_mem [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req;
  logic             hit;
  logic [LINE_W-1:0] victim_line;

  logic store_hit;
  logic wb_done;
  logic fill_done;
  logic miss_start;

  assign off = cpu_addr[OFF_W-1:0];
  assign idx = cpu_addr[OFF_W +: IDX_W];
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req = cpu_re | cpu_we;
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);
  assign miss_cnt = cnt_q;

  // Flatten the indexed line for write-back, word 0 in the LSBs.
  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_victim
    assign victim_line[w*DATA_W +: DATA_W] = data_mem[idx][w];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, pipeline responses and memory request outputs.
  always_comb begin
    state_d    = state_q;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    store_hit  = 1'b0;
    wb_done    = 1'b0;
    fill_done  = 1'b0;
    miss_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (cpu_we) store_hit = 1'b1;
            else        cpu_rdata = data_mem[idx][off];
          end else begin
            cpu_stall  = 1'b1;
            miss_start = 1'b1;
            state_d    = (valid_q[idx] && dirty_q[idx]) ? WRBACK : FILL;
          end
        end
      end
      WRBACK: begin
        cpu_stall  = 1'b1;
        mem_wr_req = 1'b1;
        mem_addr   = LADDR_W'({tag_mem[idx], idx});
        mem_wdata  = victim_line;
        if (mem_ready) begin
          wb_done = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        cpu_stall  = 1'b1;
        mem_rd_req = 1'b1;
        mem_addr   = cpu_addr[ADDR_W-1:OFF_W];
        if (mem_ready) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid and dirty bookkeeping; reset invalidates every line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wb_done) begin
      dirty_q[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Data and tag arrays: line fill or single-word store.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_mem[idx][OFF_W'(w)] <= mem_rdata[w*DATA_W +: DATA_W];
      end
      tag_mem[idx] <= tag;
    end else if (store_hit) begin
      data_mem[idx][off] <= cpu_wdata;
    end
  end

  // Saturating miss counter, bumped on every miss leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (miss_start && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
